// File: rtl/uart_inst_rx_if.sv
// uart_inst_rx_if: valid/ready byte channel from the UART receiver to the instruction decoder
interface uart_inst_rx_if;
    logic [7:0] o_data;
    logic       o_vld;
    logic       i_rdy;
    modport master (output o_data, o_vld, input i_rdy);
    modport slave (input o_data, o_vld, output i_rdy);
endinterface

// File: rtl/uart_inst_rx.sv
// uart_inst_rx: 8N1 receiver with mid-bit sampling, glitch/framing checks and a one-entry holding register
module uart_inst_rx #(
    parameter int CLK_FREQ = 100000000,
    parameter int BAUD     = 1000000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rx,
    uart_inst_rx_if.master bus,
    output logic          o_frame_err,
    output logic          o_overrun,
    output logic          o_busy
);
    localparam int DIV = CLK_FREQ / BAUD;
    localparam int CW  = $clog2(DIV);
    localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
    state_t        state_q, state_d;
    logic [1:0]    sync_q;
    logic          rx_s;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    sh_q, sh_d, data_q, data_d;
    logic          vld_q, vld_d, ferr_q, ferr_d, ovr_q, ovr_d;
    assign rx_s = sync_q[1];
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        sh_d    = sh_q;
        data_d  = data_q;
        vld_d   = vld_q & ~bus.i_rdy;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d   = '0;
                state_d = rx_s ? IDLE : START;
            end
            START: if (cnt_q == HALF) begin
                cnt_d   = '0;
                idx_d   = '0;
                state_d = rx_s ? IDLE : DATA;
            end
            DATA: if (cnt_q == LAST) begin
                cnt_d   = '0;
                sh_d    = {rx_s, sh_q[7:1]};
                idx_d   = idx_q + 3'd1;
                state_d = (idx_q == 3'd7) ? STOP : DATA;
            end
            STOP: if (cnt_q == LAST) begin
                cnt_d   = '0;
                state_d = rx_s ? IDLE : WAIT_HIGH;
                ferr_d  = ~rx_s;
                // an accept in the same cycle frees the slot, so this is a load, not an overrun
                if (rx_s && (!vld_q || bus.i_rdy)) begin
                    data_d = sh_q;
                    vld_d  = 1'b1;
                end
                ovr_d = rx_s & vld_q & ~bus.i_rdy;
            end
            WAIT_HIGH: begin
                cnt_d   = '0;
                state_d = rx_s ? IDLE : WAIT_HIGH;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 2'b11;
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
            data_q  <= '0;
            vld_q   <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], rx};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            data_q  <= data_d;
            vld_q   <= vld_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end
    assign bus.o_data  = data_q;
    assign bus.o_vld   = vld_q;
    assign o_frame_err = ferr_q;
    assign o_overrun   = ovr_q;
    assign o_busy      = (state_q != IDLE);
endmodule
